// File: rtl/shift_right.sv
// shift_right: button-driven LED pattern rotator with width select and idle timeout.
// Define SHIFT_RIGHT_SYNC_EN to add a 2-flop synchronizer on each button input.
module shift_right #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic       Reconfigure,
    input  logic       Shift_right,
    output logic [9:0] LED,
    output logic       LED_timeout,
    input  logic       clk,
    input  logic       rst
);
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
    logic       rc_s, sh_s, rc_ev, sh_ev, ev;
    logic       rc_prev_q, sh_prev_q, to_q, to_d;
    logic [9:0] pat_q, pat_d, led_q, led_d;
    logic [2:0] wid_q, wid_d;
    logic [15:0] cnt_q, cnt_d;
`ifdef SHIFT_RIGHT_SYNC_EN
    logic [1:0] rc_sync_q, sh_sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_sync_q <= '0;
            sh_sync_q <= '0;
        end else begin
            rc_sync_q <= {rc_sync_q[0], Reconfigure};
            sh_sync_q <= {sh_sync_q[0], Shift_right};
        end
    end
    assign rc_s = rc_sync_q[1];
    assign sh_s = sh_sync_q[1];
`else
    assign rc_s = Reconfigure;
    assign sh_s = Shift_right;
`endif
    assign rc_ev = rc_s & ~rc_prev_q;
    assign sh_ev = sh_s & ~sh_prev_q;
    assign ev    = rc_ev | sh_ev;
    // An event while timed out only wakes the block; reconfigure beats shift.
    always_comb begin
        wid_d = (rc_ev && !to_q) ? ((wid_q == 3'd4) ? 3'd1 : wid_q + 3'd1) : wid_q;
        pat_d = to_q ? pat_q : rc_ev ? ~(10'h3ff >> wid_d) : sh_ev ? {pat_q[0], pat_q[9:1]} : pat_q;
        cnt_d = ev ? 16'd0 : (cnt_q == TMO) ? TMO : cnt_q + 16'd1;
        to_d  = cnt_d == TMO;
        led_d = to_d ? 10'd0 : pat_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_prev_q <= 1'b0;
            sh_prev_q <= 1'b0;
            pat_q     <= 10'b1000000000;
            wid_q     <= 3'd1;
            cnt_q     <= 16'd0;
            to_q      <= 1'b0;
            led_q     <= 10'b1000000000;
        end else begin
            rc_prev_q <= rc_s;
            sh_prev_q <= sh_s;
            pat_q     <= pat_d;
            wid_q     <= wid_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            led_q     <= led_d;
        end
    end
    assign LED         = led_q;
    assign LED_timeout = to_q;
endmodule

// File: tb/tb_shift_right.sv
// tb_shift_right: directed self-checking bench for shift_right.
module tb_shift_right;
`ifdef SHIFT_RIGHT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic       clk, rst, Reconfigure, Shift_right, LED_timeout;
    logic [9:0] LED;
    int         errors = 0, checks = 0;

    shift_right #(.TIMEOUT_CYCLES(40)) dut (
        .Reconfigure(Reconfigure),
        .Shift_right(Shift_right),
        .LED(LED),
        .LED_timeout(LED_timeout),
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise the chosen buttons for hold cycles; returns half a cycle after the event edge (or after release).
    task automatic press(input logic rc, input logic sh, input int hold);
        int n;
        n = (hold > LAT) ? hold : LAT;
        @(negedge clk);
        Reconfigure = rc;
        Shift_right = sh;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == hold) begin
                Reconfigure = 1'b0;
                Shift_right = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        Reconfigure = 1'b0;
        Shift_right = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (LED !== 10'b1000000000) begin errors++; $display("FAIL reset_led_in_rst got=%b exp=%b", LED, 10'b1000000000); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (LED !== 10'b1000000000) begin errors++; $display("FAIL reset_led got=%b exp=%b", LED, 10'b1000000000); end
        checks++;
        if (LED_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", LED_timeout); end
    endtask

    task automatic test_shift_seq;
        logic [9:0] seq [5] = '{10'b0100000000, 10'b0010000000, 10'b0001000000, 10'b0000100000, 10'b0000010000};
        logic [9:0] old;
        old = 10'b1000000000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Shift_right = 1'b1;
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                if (k == 1) Shift_right = 1'b0;
                checks++;
                if (k < LAT) begin
                    if (LED !== old) begin errors++; $display("FAIL shift_early[%0d] got=%b exp=%b", i, LED, old); end
                end else begin
                    if (LED !== seq[i]) begin errors++; $display("FAIL shift_seq[%0d] got=%b exp=%b", i, LED, seq[i]); end
                end
            end
            checks++;
            if (LED_timeout !== 1'b0) begin errors++; $display("FAIL shift_timeout[%0d] got=%b exp=0", i, LED_timeout); end
            old = seq[i];
            repeat (20 - LAT) @(negedge clk);
        end
    endtask

    task automatic test_wrap_and_hold;
        for (int i = 0; i < 10; i++) press(1'b0, 1'b1, 1);
        checks++;
        if (LED !== 10'b0000010000) begin errors++; $display("FAIL wrap10 got=%b exp=%b", LED, 10'b0000010000); end
        press(1'b0, 1'b1, 5);
        repeat (4) @(negedge clk);
        checks++;
        if (LED !== 10'b0000001000) begin errors++; $display("FAIL hold_one_shift got=%b exp=%b", LED, 10'b0000001000); end
    endtask

    task automatic test_timeout;
        press(1'b0, 1'b1, 1);
        checks++;
        if (LED !== 10'b0000000100) begin errors++; $display("FAIL pre_timeout_led got=%b exp=%b", LED, 10'b0000000100); end
        repeat (39) @(negedge clk);
        checks++;
        if (LED_timeout !== 1'b0 || LED !== 10'b0000000100) begin errors++; $display("FAIL timeout_39 got=%b/%b exp=0/%b", LED_timeout, LED, 10'b0000000100); end
        @(negedge clk);
        checks++;
        if (LED_timeout !== 1'b1 || LED !== 10'd0) begin errors++; $display("FAIL timeout_40 got=%b/%b exp=1/%b", LED_timeout, LED, 10'd0); end
        repeat (10) @(negedge clk);
        checks++;
        if (LED_timeout !== 1'b1 || LED !== 10'd0) begin errors++; $display("FAIL timeout_hold got=%b/%b exp=1/%b", LED_timeout, LED, 10'd0); end
        press(1'b1, 1'b0, 1);
        checks++;
        if (LED_timeout !== 1'b0 || LED !== 10'b0000000100) begin errors++; $display("FAIL wake got=%b/%b exp=0/%b", LED_timeout, LED, 10'b0000000100); end
        press(1'b1, 1'b0, 1);
        checks++;
        if (LED !== 10'b1100000000) begin errors++; $display("FAIL reconf_after_wake got=%b exp=%b", LED, 10'b1100000000); end
    endtask

    task automatic test_simultaneous;
        press(1'b1, 1'b1, 1);
        checks++;
        if (LED !== 10'b1110000000) begin errors++; $display("FAIL simul_reconf got=%b exp=%b", LED, 10'b1110000000); end
        press(1'b0, 1'b1, 1);
        checks++;
        if (LED !== 10'b0111000000) begin errors++; $display("FAIL shift_w3 got=%b exp=%b", LED, 10'b0111000000); end
        press(1'b1, 1'b0, 1);
        checks++;
        if (LED !== 10'b1111000000) begin errors++; $display("FAIL reconf_w4 got=%b exp=%b", LED, 10'b1111000000); end
        press(1'b1, 1'b0, 1);
        checks++;
        if (LED !== 10'b1000000000) begin errors++; $display("FAIL reconf_wrap_w1 got=%b exp=%b", LED, 10'b1000000000); end
    endtask

    task automatic test_mid_reset;
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 1);
        checks++;
        if (LED !== 10'b0110000000) begin errors++; $display("FAIL pre_reset_led got=%b exp=%b", LED, 10'b0110000000); end
        @(negedge clk);
        rst = 1'b1;
        Shift_right = 1'b1;
        @(negedge clk);
        checks++;
        if (LED !== 10'b1000000000 || LED_timeout !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%b exp=%b/0", LED, LED_timeout, 10'b1000000000); end
        rst = 1'b0;
        Shift_right = 1'b0;
        press(1'b1, 1'b0, 1);
        checks++;
        if (LED !== 10'b1100000000) begin errors++; $display("FAIL wid_after_reset got=%b exp=%b", LED, 10'b1100000000); end
    endtask

    initial begin
        test_reset;
        test_shift_seq;
        test_wrap_and_hold;
        test_timeout;
        test_simultaneous;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
